traffic_sequencer: RTL and testbench
====================================

Name: traffic_sequencer

Overview:
- Consumer end of the clock-divider interface. Takes the divider's slow `clk_div` level signal and turns its rising edges into single-cycle ticks in the `clk` domain.
- Uses those ticks to time a two-road (main/side) traffic-light phase sequence, with a pedestrian walk request.
- Sits directly downstream of the divider; drives the light/LED outputs of the controller top level.

Parameters:
- GREEN_MAIN, 8, minimum main-road green length in ticks (>=1)
- GREEN_SIDE, 5, side-road green length in ticks (>=1)
- YELLOW_T, 2, yellow length in ticks, both roads (>=1)
- ALL_RED_T, 1, all-red clearance length in ticks (>=1)
- CNT_W, 4, phase timer width; every length-1 must fit in CNT_W bits

Ports:
- clk  in  1  system clock, the same clock that feeds the divider
- rst  in  1  synchronous, active-high reset
- clk_div  in  1  divided clock from the divider, sampled as a level in the clk domain
- side_car  in  1  side-road vehicle present (level)
- ped_req  in  1  pedestrian request (any-width pulse or level)
- main_light  out  3  {R,Y,G} one-hot, main road
- side_light  out  3  {R,Y,G} one-hot, side road
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding, 0..5 as listed below
- timer  out  CNT_W  ticks remaining in the current phase, minus 1

Behaviour:
- Tick generation
  - clk_div_q <= clk_div every cycle.
  - tick = clk_div & ~clk_div_q (combinational).
  - The state and timer update on the clk edge in which tick is high.
  - clk_div_q resets to 0, so a clk_div already high at reset release produces a tick on the first cycle.
- States and phase codes
  - MAIN_G=0, MAIN_Y=1, RED1=2, SIDE_G=3, SIDE_Y=4, RED2=5.
  - Transition order: MAIN_G->MAIN_Y->RED1->SIDE_G->SIDE_Y->RED2->MAIN_G.
- Timer
  - On entering a phase of length N, timer loads N-1.
  - On each tick: if timer != 0, decrement; if timer == 0, advance to the next state and load the next phase's length-1.
  - Each phase therefore lasts exactly N ticks.
- MAIN_G extension
  - At timer == 0 on a tick, advance only if (side_car | ped_pend).
  - Otherwise stay in MAIN_G with timer held at 0; advance on the first later tick where the condition is true.
- ped_pend
  - Set in any cycle where ped_req=1, except when state == SIDE_G and walk == 1 (request absorbed).
  - Cleared on the clk edge that enters SIDE_G; that same edge sets walk = old ped_pend.
  - If ped_req=1 on the entry edge itself, it is absorbed when walk becomes 1, and latched otherwise.
- walk: cleared on the edge leaving SIDE_G; 0 in every other state.
- Registered outputs, decoded from the next state so they change on the same edge as phase:
  - main_light = 001 in MAIN_G, 010 in MAIN_Y, 100 in all other states.
  - side_light = 001 in SIDE_G, 010 in SIDE_Y, 100 in all other states.
  - Never both roads non-red. In RED1/RED2 both roads are 100.
- Reset values (rst=1 wins over tick in the same cycle; rst mid-phase aborts immediately to these values):
  - state=MAIN_G, timer=GREEN_MAIN-1
  - main_light=001, side_light=100
  - walk=0, ped_pend=0, clk_div_q=0
- clk_div held constant: no ticks, all state frozen; ped_pend may still set.
- clk_div high for many clk cycles: exactly one tick per rising edge.
- Reachable codes are 0..5 only; codes 6/7 recover to MAIN_G reset values on the next clk edge.

Test Plan:
- Reset with clk_div toggling every 10 clk cycles (matching divider bench: clk period 10 ns, rst pulse 10-20 ns), side_car=0, ped_req=0 -> phase stays 0, main_light=001, side_light=100 indefinitely; timer counts 7..0 then holds at 0.
- side_car=1 from reset -> phase sequence 0,1,2,3,4,5,0 with dwell of 8,2,1,5,2,1 ticks; side_light=001 only in phase 3; walk stays 0.
- side_car=0, single 1-cycle ped_req pulse during MAIN_G tick 3 -> advance at tick 8; walk=1 for all 5 SIDE_G ticks; ped_pend=0 afterwards; next MAIN_G holds without advancing.
- ped_req pulsed during SIDE_G with walk=1 -> absorbed, no second walk. ped_req pulsed during SIDE_Y -> latched; the next MAIN_G advances at its minimum length.
- clk_div held high for 50 cycles then low -> exactly one tick; timer decrements by 1 only.
- rst=1 asserted mid-SIDE_G coincident with a tick -> next cycle phase=0, timer=7, side_light=100, walk=0.

Source files
------------

// File: rtl/traffic_sequencer.sv
// Two-road traffic-light sequencer timed by rising edges of the divider's clk_div.
// Phases: MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2, with a pedestrian walk request.
module traffic_sequencer #(
  parameter int GREEN_MAIN = 8,
  parameter int GREEN_SIDE = 5,
  parameter int YELLOW_T   = 2,
  parameter int ALL_RED_T  = 1,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             side_car,
  input  logic             ped_req,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED2   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LEN_MG = CNT_W'(GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] LEN_SG = CNT_W'(GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] LEN_Y  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LEN_AR = CNT_W'(ALL_RED_T - 1);

  localparam logic [2:0] LIGHT_G = 3'b001;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_R = 3'b100;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             clk_div_q, clk_div_d;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_q, walk_d;
  logic [2:0]       main_light_q, main_light_d;
  logic [2:0]       side_light_q, side_light_d;
  logic             tick;
  logic             expired;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    clk_div_d  = clk_div;
    tick       = clk_div & ~clk_div_q;
    expired    = tick && (timer_q == '0);
    state_d    = state_q;
    timer_d    = timer_q;
    walk_d     = walk_q;
    ped_pend_d = ped_pend_q;

    // A request while the walk lamp is already lit is served by the current walk.
    if (ped_req && !(state_q == SIDE_G && walk_q)) ped_pend_d = 1'b1;
    if (tick && timer_q != '0) timer_d = timer_q - 1'b1;

    case (state_q)
      MAIN_G: if (expired && (side_car || ped_pend_q)) begin
        state_d = MAIN_Y;
        timer_d = LEN_Y;
      end
      MAIN_Y: if (expired) begin
        state_d = RED1;
        timer_d = LEN_AR;
      end
      RED1: if (expired) begin
        state_d    = SIDE_G;
        timer_d    = LEN_SG;
        walk_d     = ped_pend_q;
        ped_pend_d = ped_req && !ped_pend_q;
      end
      SIDE_G: if (expired) begin
        state_d = SIDE_Y;
        timer_d = LEN_Y;
        walk_d  = 1'b0;
      end
      SIDE_Y: if (expired) begin
        state_d = RED2;
        timer_d = LEN_AR;
      end
      RED2: if (expired) begin
        state_d = MAIN_G;
        timer_d = LEN_MG;
      end
      default: begin
        // Unreachable codes fall back to the reset phase on the next edge.
        state_d    = MAIN_G;
        timer_d    = LEN_MG;
        walk_d     = 1'b0;
        ped_pend_d = 1'b0;
      end
    endcase

    main_light_d = LIGHT_R;
    side_light_d = LIGHT_R;
    case (state_d)
      MAIN_G:  main_light_d = LIGHT_G;
      MAIN_Y:  main_light_d = LIGHT_Y;
      SIDE_G:  side_light_d = LIGHT_G;
      SIDE_Y:  side_light_d = LIGHT_Y;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MAIN_G;
      timer_q      <= LEN_MG;
      clk_div_q    <= 1'b0;
      ped_pend_q   <= 1'b0;
      walk_q       <= 1'b0;
      main_light_q <= LIGHT_G;
      side_light_q <= LIGHT_R;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      clk_div_q    <= clk_div_d;
      ped_pend_q   <= ped_pend_d;
      walk_q       <= walk_d;
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
    end
  end

  assign main_light = main_light_q;
  assign side_light = side_light_q;
  assign walk       = walk_q;
  assign phase      = state_q;
  assign timer      = timer_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer: a vector table for the full side_car cycle
// plus hand-written sequences for pedestrian, held-high clk_div and reset corners.
module tb_traffic_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_div = 1'b0;
  logic       side_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       walk;
  logic [3:0] timer;

  int total = 0;
  int bad   = 0;

  traffic_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .side_car   (side_car),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .phase      (phase),
    .timer      (timer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       side_car;
    logic       ped_req;
    logic [2:0] phase;
    logic [3:0] timer;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ph, input logic [3:0] tm,
                           input logic [2:0] ml, input logic [2:0] sl, input logic wk);
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".timer"}, 32'(timer), 32'(tm));
    check({tag, ".main"}, 32'(main_light), 32'(ml));
    check({tag, ".side"}, 32'(side_light), 32'(sl));
    check({tag, ".walk"}, 32'(walk), 32'(wk));
  endtask

  // One clk_div rising edge: high for one clk, then low for one clk; returns at a negedge.
  task automatic do_tick();
    @(negedge clk) clk_div = 1'b1;
    @(negedge clk) clk_div = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic ped_pulse();
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clk_div = 1'b0; side_car = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 4'd6, 3'b001, 3'b100, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 4'd5, 3'b001, 3'b100, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 4'd4, 3'b001, 3'b100, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd0, 4'd3, 3'b001, 3'b100, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 4'd2, 3'b001, 3'b100, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 4'd1, 3'b001, 3'b100, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 4'd0, 3'b001, 3'b100, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd1, 4'd1, 3'b010, 3'b100, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'd1, 4'd0, 3'b010, 3'b100, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'd2, 4'd0, 3'b100, 3'b100, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 4'd4, 3'b100, 3'b001, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'd3, 4'd3, 3'b100, 3'b001, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'd3, 4'd2, 3'b100, 3'b001, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'd3, 4'd1, 3'b100, 3'b001, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'd3, 4'd0, 3'b100, 3'b001, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'd4, 4'd1, 3'b100, 3'b010, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'd4, 4'd0, 3'b100, 3'b010, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd5, 4'd0, 3'b100, 3'b100, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'd0, 4'd7, 3'b001, 3'b100, 1'b0};

    // Reset state, then idle with clk_div toggling every 10 clk cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset", 3'd0, 4'd7, 3'b001, 3'b100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) clk_div = 1'b1;
      repeat (9) @(negedge clk);
      clk_div = 1'b0;
      repeat (10) @(negedge clk);
      check("idle.timer", 32'(timer), (i >= 7) ? 32'd0 : 32'(6 - i));
      check("idle.phase", 32'(phase), 32'd0);
    end
    check_all("idle.end", 3'd0, 4'd0, 3'b001, 3'b100, 1'b0);

    // Full cycle with a car waiting on the side road.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      side_car = vecs[i].side_car;
      ped_req  = vecs[i].ped_req;
      do_tick();
      check_all($sformatf("vec%0d", i), vecs[i].phase, vecs[i].timer,
                vecs[i].main_l, vecs[i].side_l, vecs[i].walk);
    end

    // Pedestrian pulse during MAIN_G tick 3 advances at the minimum length.
    do_reset();
    ticks(3);
    ped_pulse();
    ticks(4);
    check_all("ped.mg_end", 3'd0, 4'd0, 3'b001, 3'b100, 1'b0);
    do_tick();
    check("ped.adv8", 32'(phase), 32'd1);
    ticks(2);
    check_all("ped.red1", 3'd2, 4'd0, 3'b100, 3'b100, 1'b0);
    do_tick();
    check_all("ped.sg0", 3'd3, 4'd4, 3'b100, 3'b001, 1'b1);
    do_tick();
    ped_pulse();
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check("ped.sg_walk", 32'(walk), 32'd1);
    end
    do_tick();
    check_all("ped.sy", 3'd4, 4'd1, 3'b100, 3'b010, 1'b0);
    ticks(3);
    check_all("ped.mg_again", 3'd0, 4'd7, 3'b001, 3'b100, 1'b0);
    ticks(12);
    check_all("ped.absorbed_hold", 3'd0, 4'd0, 3'b001, 3'b100, 1'b0);

    // Car forces the next cycle; no second walk; request in SIDE_Y is latched.
    side_car = 1'b1;
    do_tick();
    side_car = 1'b0;
    check("car.adv", 32'(phase), 32'd1);
    ticks(3);
    check_all("car.sg_nowalk", 3'd3, 4'd4, 3'b100, 3'b001, 1'b0);
    ticks(5);
    check("car.sy", 32'(phase), 32'd4);
    ped_pulse();
    ticks(3);
    check_all("lat.mg", 3'd0, 4'd7, 3'b001, 3'b100, 1'b0);
    ticks(7);
    check_all("lat.mg_end", 3'd0, 4'd0, 3'b001, 3'b100, 1'b0);
    do_tick();
    check("lat.adv", 32'(phase), 32'd1);
    ticks(3);
    check("lat.walk", 32'(walk), 32'd1);

    // clk_div held high for 50 cycles yields a single tick.
    do_reset();
    do_tick();
    check("hold.pre", 32'(timer), 32'd6);
    @(negedge clk) clk_div = 1'b1;
    repeat (50) @(negedge clk);
    clk_div = 1'b0;
    repeat (3) @(negedge clk);
    check("hold.timer", 32'(timer), 32'd5);
    check("hold.phase", 32'(phase), 32'd0);

    // clk_div high through reset: reset wins, then a tick on the first free cycle.
    @(negedge clk);
    rst = 1'b1; clk_div = 1'b1;
    repeat (2) @(negedge clk);
    check("rsthi.during", 32'(timer), 32'd7);
    rst = 1'b0;
    @(negedge clk);
    check("rsthi.first_tick", 32'(timer), 32'd6);
    clk_div = 1'b0;

    // Reset coincident with a tick in the middle of a walk phase.
    do_reset();
    side_car = 1'b1;
    ped_pulse();
    ticks(12);
    check_all("mid.sg", 3'd3, 4'd3, 3'b100, 3'b001, 1'b1);
    @(negedge clk);
    clk_div = 1'b1; rst = 1'b1;
    @(negedge clk);
    check_all("mid.rst", 3'd0, 4'd7, 3'b001, 3'b100, 1'b0);
    rst = 1'b0; clk_div = 1'b0; side_car = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
